// File: rtl/pixel_write_master.sv
// rtl/pixel_write_master.sv - queued (address, pixel) writes issued as AXI4-Lite single-beat writes
//
// Purpose: accepts write requests from the transform unit into a small FIFO and drains them one at a
// time onto an AXI4-Lite AW/W/B master port. One transaction is outstanding at any time; completions
// are counted and any non-OKAY write response sets a sticky error flag.
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   REQ_VALID/REQ_READY          request handshake; REQ_ADDR/REQ_DATA carry the write
//   M_AW*/M_W*/M_B*              AXI4-Lite write address, write data and write response channels
//   ERR_CLR                      clears ERR (a simultaneous error response wins)
//   BUSY                         requests queued or a transaction in progress
//   ERR                          sticky error-response flag
//   WR_COUNT                     completed writes, wraps at 16 bits

module pixel_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      REQ_VALID,
    input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]     REQ_DATA,
    output logic                      REQ_READY,
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic [2:0]                M_AWPROT,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    input  logic                      ERR_CLR,
    output logic                      BUSY,
    output logic                      ERR,
    output logic [15:0]               WR_COUNT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request FIFO
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  push, pop;

    // Transaction state
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  err_q, err_d;
    logic [15:0]           wr_count_q, wr_count_d;

    // A channel counts as done if it already handshook earlier or is handshaking this cycle.
    logic                  aw_done, w_done;

    assign REQ_READY = (count_q != FULL_CNT);
    assign push      = REQ_VALID && REQ_READY;
    assign aw_done   = !awvalid_q || M_AWREADY;
    assign w_done    = !wvalid_q || M_WREADY;

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= REQ_ADDR;
            fifo_data_q[wr_ptr_q] <= REQ_DATA;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        wr_count_d = wr_count_q;
        err_d      = ERR_CLR ? 1'b0 : err_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    awaddr_d  = fifo_addr_q[rd_ptr_q];
                    wdata_d   = fifo_data_q[rd_ptr_q];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // AW and W retire independently; B is only accepted once both are done.
                if (awvalid_q && M_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (M_BVALID) begin
                    bready_d   = 1'b0;
                    wr_count_d = wr_count_q + 16'd1;
                    if (M_BRESP != 2'b00) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign M_AWADDR  = awaddr_q;
    assign M_AWPROT  = 3'b000;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = '1;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign BUSY      = (count_q != '0) || (state_q != IDLE);
    assign ERR       = err_q;
    assign WR_COUNT  = wr_count_q;

endmodule

// File: tb/tb_pixel_write_master.sv
// tb/tb_pixel_write_master.sv - randomized transaction-level check of pixel_write_master
module tb_pixel_write_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        REQ_VALID;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_DATA;
    logic        REQ_READY;
    logic [31:0] M_AWADDR;
    logic [2:0]  M_AWPROT;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY;
    logic [1:0]  M_BRESP;
    logic        M_BVALID;
    logic        M_BREADY;
    logic        ERR_CLR;
    logic        BUSY;
    logic        ERR;
    logic [15:0] WR_COUNT;

    always #5 ACLK = ~ACLK;

    pixel_write_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .REQ_VALID (REQ_VALID),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .M_AWADDR  (M_AWADDR),
        .M_AWPROT  (M_AWPROT),
        .M_AWVALID (M_AWVALID),
        .M_AWREADY (M_AWREADY),
        .M_WDATA   (M_WDATA),
        .M_WSTRB   (M_WSTRB),
        .M_WVALID  (M_WVALID),
        .M_WREADY  (M_WREADY),
        .M_BRESP   (M_BRESP),
        .M_BVALID  (M_BVALID),
        .M_BREADY  (M_BREADY),
        .ERR_CLR   (ERR_CLR),
        .BUSY      (BUSY),
        .ERR       (ERR),
        .WR_COUNT  (WR_COUNT)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    // Reference model: queued requests plus the one transaction in flight.
    req_t        m_q[$];
    req_t        m_cur;
    bit          m_busy, m_aw_pend, m_w_pend, m_b_wait, m_err;
    logic [15:0] m_count;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur    = '{addr: 32'h0, data: 32'h0};
        m_busy   = 0;
        m_aw_pend = 0;
        m_w_pend = 0;
        m_b_wait = 0;
        m_err    = 0;
        m_count  = 16'h0;
    endtask

    // Called just after a falling edge with inputs already set: check outputs, advance model, step.
    task automatic tick();
        int  pre_size;
        bit  b_hs;
        req_t r;
        check_val("req_ready", REQ_READY, m_q.size() != 4);
        check_val("awvalid", M_AWVALID, m_aw_pend);
        check_val("wvalid", M_WVALID, m_w_pend);
        check_val("bready", M_BREADY, m_b_wait);
        check_val("busy", BUSY, m_busy || m_q.size() != 0);
        check_val("err", ERR, m_err);
        check_val("wr_count", WR_COUNT, m_count);
        if (m_aw_pend) check_val("awaddr", M_AWADDR, m_cur.addr);
        if (m_w_pend) check_val("wdata", M_WDATA, m_cur.data);

        if (ARESET) begin
            model_reset();
        end else begin
            pre_size = m_q.size();
            b_hs = m_b_wait && M_BVALID;
            if (b_hs) begin
                m_count++;
                m_b_wait = 0;
                m_busy   = 0;
            end else if (m_busy && !m_b_wait) begin
                if (m_aw_pend && M_AWREADY) m_aw_pend = 0;
                if (m_w_pend && M_WREADY) m_w_pend = 0;
                if (!m_aw_pend && !m_w_pend) m_b_wait = 1;
            end else if (!m_busy && pre_size != 0) begin
                m_cur     = m_q.pop_front();
                m_busy    = 1;
                m_aw_pend = 1;
                m_w_pend  = 1;
            end
            if (b_hs && M_BRESP != 2'b00) m_err = 1;
            else if (ERR_CLR) m_err = 0;
            if (REQ_VALID && pre_size != 4) begin
                r.addr = REQ_ADDR;
                r.data = REQ_DATA;
                m_q.push_back(r);
            end
        end
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic run_phase(input int n, input int p_req, input int p_aw, input int p_w,
                             input int p_b, input int p_slverr, input int p_clr, input int p_rst);
        for (int i = 0; i < n; i++) begin
            ARESET    = ($urandom_range(0, 999) < p_rst);
            REQ_VALID = ($urandom_range(0, 99) < p_req);
            REQ_ADDR  = $urandom() & 32'hFFFF_FFFC;
            REQ_DATA  = $urandom();
            M_AWREADY = ($urandom_range(0, 99) < p_aw);
            M_WREADY  = ($urandom_range(0, 99) < p_w);
            M_BVALID  = ($urandom_range(0, 99) < p_b);
            M_BRESP   = ($urandom_range(0, 99) < p_slverr) ? 2'b10 : 2'b00;
            ERR_CLR   = ($urandom_range(0, 99) < p_clr);
            tick();
        end
    endtask

    task automatic idle_inputs();
        ARESET = 0; REQ_VALID = 0; REQ_ADDR = 0; REQ_DATA = 0;
        M_AWREADY = 1; M_WREADY = 1; M_BVALID = 1; M_BRESP = 2'b00; ERR_CLR = 0;
    endtask

    initial begin
        idle_inputs();
        ARESET = 1;
        @(negedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        model_reset();
        check_val("rst_awaddr", M_AWADDR, 32'h0);
        check_val("rst_wdata", M_WDATA, 32'h0);
        check_val("awprot", M_AWPROT, 3'b000);
        check_val("wstrb", M_WSTRB, 4'hF);
        ARESET = 0;
        tick();

        // Single write, zero-wait slave
        REQ_VALID = 1; REQ_ADDR = 32'h1000; REQ_DATA = 32'hA5A5A5A5;
        tick();
        REQ_VALID = 0;
        for (int i = 0; i < 8; i++) tick();
        check_val("single_count", WR_COUNT, 16'd1);

        // Fill FIFO while the address channel stalls, then release
        run_phase(10, 100, 0, 100, 100, 0, 0, 0);
        run_phase(30, 0, 100, 100, 100, 0, 0, 0);

        // W accepted well before AW
        REQ_VALID = 1; REQ_ADDR = 32'h2000; REQ_DATA = 32'h1234_5678;
        M_AWREADY = 0; M_WREADY = 1;
        tick();
        REQ_VALID = 0;
        for (int i = 0; i < 4; i++) tick();
        M_AWREADY = 1;
        for (int i = 0; i < 6; i++) tick();

        // Error responses with clears, including clears coinciding with SLVERR
        run_phase(300, 60, 70, 70, 50, 40, 20, 0);
        M_BRESP = 2'b10; ERR_CLR = 1; REQ_VALID = 1; REQ_ADDR = 32'h3000; REQ_DATA = 32'h0;
        tick();
        REQ_VALID = 0;
        for (int i = 0; i < 8; i++) tick();
        M_BRESP = 2'b00;
        tick();
        ERR_CLR = 0;
        tick();

        // General random traffic with occasional resets mid-transaction
        run_phase(1500, 50, 60, 60, 60, 10, 5, 8);
        run_phase(1000, 80, 30, 30, 40, 10, 5, 0);

        // Reset while queued requests are waiting behind a stalled transfer
        run_phase(8, 100, 0, 0, 0, 0, 0, 0);
        ARESET = 1; REQ_VALID = 0;
        tick();
        ARESET = 0;
        run_phase(100, 30, 100, 100, 100, 0, 0, 0);

        idle_inputs();
        for (int i = 0; i < 20; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
